keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad, synchronises and debounces the row returns, and encodes one press into a 4-bit key code with a single-cycle valid strobe.
- Shifts digit keys into a 4-digit entry buffer.
- Produces the `key` and new-time digit values consumed by the display driver and the alarm/time-set logic. It is the input end of the digit path the display driver renders.

---
 rtl/keypad_scanner_pkg.sv | 56 +++++
 rtl/keypad_scanner_key_buffer.sv | 39 +++
 rtl/keypad_scanner.sv | 150 +++++++++++++++
 tb/tb_keypad_scanner.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key codes,
// column-drive reset pattern and the row/column to key-code map.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_e;

   localparam logic [3:0] KEY_A    = 4'd10;
   localparam logic [3:0] KEY_B    = 4'd11;
   localparam logic [3:0] KEY_C    = 4'd12;
   localparam logic [3:0] KEY_D    = 4'd13;
   localparam logic [3:0] KEY_STAR = 4'd14;
   localparam logic [3:0] KEY_HASH = 4'd15;

   localparam logic [3:0] COL_RESET = 4'b1110;

   function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      code = 4'd0;
      case ({row, col})
         4'h0: code = 4'd1;
         4'h1: code = 4'd2;
         4'h2: code = 4'd3;
         4'h3: code = KEY_A;
         4'h4: code = 4'd4;
         4'h5: code = 4'd5;
         4'h6: code = 4'd6;
         4'h7: code = KEY_B;
         4'h8: code = 4'd7;
         4'h9: code = 4'd8;
         4'hA: code = 4'd9;
         4'hB: code = KEY_C;
         4'hC: code = KEY_STAR;
         4'hD: code = 4'd0;
         4'hE: code = KEY_HASH;
         4'hF: code = KEY_D;
         default: code = 4'd0;
      endcase
      return code;
   endfunction

   // Lowest-indexed active-low row; only meaningful when at least one row is low.
   function automatic logic [1:0] lowest_low(input logic [3:0] rows);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows[i]) r = 2'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/keypad_scanner_key_buffer.sv
// Four-digit BCD entry buffer: digits shift in at the low nibble, '*' empties it,
// and an explicit clear overrides any same-cycle load.
module key_buffer
   import keypad_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        load_i,
   input  logic [3:0]  code_i,
   output logic [15:0] digits_o
);

   logic [15:0] digits_q, digits_d;

   always_comb begin
      digits_d = digits_q;
      if (clear_i) begin
         digits_d = 16'h0000;
      end else if (load_i) begin
         if (code_i <= 4'd9) begin
            digits_d = {digits_q[11:0], code_i};
         end else if (code_i == KEY_STAR) begin
            digits_d = 16'h0000;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         digits_q <= 16'h0000;
      end else begin
         digits_q <= digits_d;
      end
   end

   assign digits_o = digits_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks a one-cold column drive, synchronises and debounces the
// row returns, and strobes one key code per qualified press into the digit buffer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | drive columns in turn, look for any low row at end of dwell
// DEBOUNCE | column held, row pattern must stay identical to qualify
// HELD     | key reported, waiting for all rows to go high
// RELEASE  | all rows high, must stay so to qualify the release
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SCAN_CYCLES     = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  row_in,
   output logic [3:0]  col_out,
   input  logic        clear_buffer,
   output logic [3:0]  key,
   output logic        key_valid,
   output logic        key_pressed,
   output logic [15:0] key_buffer
);

   localparam int CNT_MAX = (DEBOUNCE_CYCLES > SCAN_CYCLES) ? DEBOUNCE_CYCLES : SCAN_CYCLES;
   localparam int CW      = $clog2(CNT_MAX) + 1;
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

   logic [3:0]    rs_meta_q, rs_q;
   state_e        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    pat_q, pat_d;
   logic [1:0]    row_sel_q, row_sel_d;
   logic [3:0]    key_q, key_d;
   logic          key_valid_q, key_valid_d;
   logic          key_pressed_q, key_pressed_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         rs_meta_q     <= 4'hF;
         rs_q          <= 4'hF;
         state_q       <= SCAN;
         idx_q         <= 2'd0;
         cnt_q         <= '0;
         pat_q         <= 4'hF;
         row_sel_q     <= 2'd0;
         key_q         <= 4'd0;
         key_valid_q   <= 1'b0;
         key_pressed_q <= 1'b0;
      end else begin
         rs_meta_q     <= row_in;
         rs_q          <= rs_meta_q;
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         pat_q         <= pat_d;
         row_sel_q     <= row_sel_d;
         key_q         <= key_d;
         key_valid_q   <= key_valid_d;
         key_pressed_q <= key_pressed_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      pat_d         = pat_q;
      row_sel_d     = row_sel_q;
      key_d         = key_q;
      key_valid_d   = 1'b0;
      key_pressed_d = key_pressed_q;
      case (state_q)
         SCAN: begin
            if (cnt_q == SCAN_LAST) begin
               cnt_d = '0;
               if (rs_q != 4'hF) begin
                  state_d   = DEBOUNCE;
                  pat_d     = rs_q;
                  row_sel_d = lowest_low(rs_q);
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (rs_q != pat_q) begin
               state_d = SCAN;
               idx_d   = idx_q + 2'd1;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d       = HELD;
               cnt_d         = '0;
               key_d         = keymap(row_sel_q, idx_q);
               key_valid_d   = 1'b1;
               key_pressed_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HELD: begin
            if (rs_q == 4'hF) begin
               state_d = RELEASE;
               cnt_d   = '0;
            end
         end
         RELEASE: begin
            // Any low row during release is bounce: fall back without a new strobe.
            if (rs_q != 4'hF) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d       = SCAN;
               cnt_d         = '0;
               idx_d         = idx_q + 2'd1;
               key_pressed_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = SCAN;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      col_out     = ~((~COL_RESET) << idx_q);
      key         = key_q;
      key_valid   = key_valid_q;
      key_pressed = key_pressed_q;
   end

   key_buffer u_key_buffer (
      .clock    (clock),
      .reset    (reset),
      .clear_i  (clear_buffer),
      .load_i   (key_valid_q),
      .code_i   (key_q),
      .digits_o (key_buffer)
   );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized bench for keypad_scanner using a contact-level keypad model
// and an arithmetic model of the digit buffer.
module tb_keypad_scanner;

   localparam int DEB = 16;
   localparam int SCN = 4;
   localparam int MAX_PRESS_LAT = 2 + 4 * SCN + DEB + 1;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic        clear_buffer;
   logic [3:0]  key;
   logic        key_valid;
   logic        key_pressed;
   logic [15:0] key_buffer;

   logic        contact;
   logic [1:0]  pr, pc;

   int vectors = 0;
   int miscompares = 0;
   int strobes = 0;
   int mbuf = 0;

   // Keypad face, index row*4+col.
   int km [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

   keypad_scanner #(.DEBOUNCE_CYCLES(DEB), .SCAN_CYCLES(SCN)) dut (
      .clock        (clock),
      .reset        (reset),
      .row_in       (row_in),
      .col_out      (col_out),
      .clear_buffer (clear_buffer),
      .key          (key),
      .key_valid    (key_valid),
      .key_pressed  (key_pressed),
      .key_buffer   (key_buffer)
   );

   always #5 clock = ~clock;

   // A closed contact pulls its row low only while its column is driven low.
   assign row_in = (contact && (col_out[pc] == 1'b0)) ? (4'hF ^ (4'b0001 << pr)) : 4'hF;

   always @(posedge clock) begin
      if (key_valid === 1'b1) strobes++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic select_key(input int code);
      for (int i = 0; i < 16; i++) begin
         if (km[i] == code) begin
            pr = 2'(i / 4);
            pc = 2'(i % 4);
         end
      end
   endtask

   function automatic int model_next(input int buf_in, input int code);
      if (code <= 9) return (buf_in * 16 + code) % 65536;
      if (code == 14) return 0;
      return buf_in;
   endfunction

   task automatic check_scan(input int n);
      logic [3:0] e;
      for (int k = 1; k <= n; k++) begin
         @(negedge clock);
         e = 4'hF ^ (4'b0001 << ((k / 4) % 4));
         chk("col_scan", {28'd0, col_out}, {28'd0, e});
      end
   endtask

   task automatic wait_strobe(input string tag, output int lat);
      lat = 0;
      while (key_valid !== 1'b1 && lat < 60) begin
         @(negedge clock);
         lat++;
      end
      chk({tag, "_latency_ok"}, (lat <= MAX_PRESS_LAT) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic wait_release(input string tag);
      int rl;
      rl = 0;
      while (key_pressed !== 1'b0 && rl < 60) begin
         @(negedge clock);
         rl++;
      end
      chk({tag, "_release_window"}, (rl >= DEB + 1 && rl <= DEB + 4) ? 32'd1 : 32'd0, 32'd1);
   endtask

   // Full clean press: contact, qualify, hold, release, then buffer against the model.
   task automatic do_press(input string tag, input int code, input int hold);
      int base, lat;
      select_key(code);
      base = strobes;
      contact = 1'b1;
      wait_strobe(tag, lat);
      chk({tag, "_key"}, {28'd0, key}, 32'(code));
      chk({tag, "_pressed"}, {31'd0, key_pressed}, 32'd1);
      tick(hold);
      contact = 1'b0;
      wait_release(tag);
      mbuf = model_next(mbuf, code);
      chk({tag, "_strobes"}, 32'(strobes - base), 32'd1);
      chk({tag, "_buffer"}, {16'd0, key_buffer}, 32'(mbuf));
   endtask

   initial begin
      int base, lat, code;
      reset = 1'b1;
      contact = 1'b0;
      clear_buffer = 1'b0;
      pr = 2'd0;
      pc = 2'd0;
      tick(3);
      chk("rst_col", {28'd0, col_out}, 32'hE);
      chk("rst_key", {28'd0, key}, 32'd0);
      chk("rst_valid", {31'd0, key_valid}, 32'd0);
      chk("rst_pressed", {31'd0, key_pressed}, 32'd0);
      chk("rst_buffer", {16'd0, key_buffer}, 32'd0);
      reset = 1'b0;
      check_scan(17);

      do_press("key5", 5, 60);
      chk("key5_buf_const", {16'd0, key_buffer}, 32'h0005);

      do_press("*a", 14, 20);
      do_press("d1", 1, 20);
      chk("seq_0001", {16'd0, key_buffer}, 32'h0001);
      do_press("d2", 2, 20);
      chk("seq_0012", {16'd0, key_buffer}, 32'h0012);
      do_press("d3", 3, 20);
      chk("seq_0123", {16'd0, key_buffer}, 32'h0123);
      do_press("d4", 4, 20);
      chk("seq_1234", {16'd0, key_buffer}, 32'h1234);
      do_press("d9", 9, 20);
      chk("seq_2349", {16'd0, key_buffer}, 32'h2349);
      do_press("star", 14, 20);
      chk("star_buf", {16'd0, key_buffer}, 32'h0000);
      chk("star_key", {28'd0, key}, 32'd14);

      // Press bounce then release bounce on '7'.
      select_key(7);
      base = strobes;
      contact = 1'b1;
      tick(5);
      contact = 1'b0;
      tick(3);
      chk("bounce_no_strobe", 32'(strobes - base), 32'd0);
      contact = 1'b1;
      wait_strobe("bounce7", lat);
      chk("bounce7_key", {28'd0, key}, 32'd7);
      tick(30);
      contact = 1'b0;
      tick(4);
      contact = 1'b1;
      tick(2);
      contact = 1'b0;
      lat = 0;
      while (key_pressed !== 1'b0 && lat < 60) begin
         @(negedge clock);
         lat++;
      end
      chk("bounce7_release", {31'd0, key_pressed}, 32'd0);
      chk("bounce7_strobes", 32'(strobes - base), 32'd1);
      mbuf = model_next(mbuf, 7);
      chk("bounce7_buf", {16'd0, key_buffer}, 32'h0007);

      // clear_buffer coincident with the '8' strobe.
      do_press("*b", 14, 10);
      do_press("c1", 1, 10);
      do_press("c2", 2, 10);
      chk("clr_pre", {16'd0, key_buffer}, 32'h0012);
      select_key(8);
      contact = 1'b1;
      wait_strobe("clr8", lat);
      clear_buffer = 1'b1;
      chk("clr8_key", {28'd0, key}, 32'd8);
      @(negedge clock);
      clear_buffer = 1'b0;
      chk("clr8_buf", {16'd0, key_buffer}, 32'h0000);
      tick(10);
      contact = 1'b0;
      wait_release("clr8");
      mbuf = 0;
      do_press("keyA", 10, 10);
      chk("keyA_buf", {16'd0, key_buffer}, 32'h0000);

      // Reset while '3' is guaranteed to be debouncing.
      select_key(3);
      base = strobes;
      contact = 1'b1;
      tick(17);
      reset = 1'b1;
      contact = 1'b0;
      tick(2);
      chk("midrst_strobes", 32'(strobes - base), 32'd0);
      chk("midrst_col", {28'd0, col_out}, 32'hE);
      chk("midrst_key", {28'd0, key}, 32'd0);
      chk("midrst_pressed", {31'd0, key_pressed}, 32'd0);
      chk("midrst_buf", {16'd0, key_buffer}, 32'd0);
      reset = 1'b0;
      mbuf = 0;
      check_scan(8);
      chk("midrst_after", 32'(strobes - base), 32'd0);

      for (int n = 0; n < 12; n++) begin
         code = int'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) begin
            clear_buffer = 1'b1;
            @(negedge clock);
            clear_buffer = 1'b0;
            mbuf = 0;
         end
         do_press("rand", code, int'($urandom_range(5, 40)));
         tick(int'($urandom_range(0, 7)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
